fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/data width in bits.
REQ-002 The block SHALL have parameter BTB_ENTRIES, default 16, meaning branch target buffer depth; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the fetch address after reset.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port stall_i  input  1  hold the current fetch PC.
REQ-007 The block SHALL have port redirect_i  input  1  misprediction or exception correction from execute.
REQ-008 The block SHALL have port redirect_pc_i  input  XLEN  corrected fetch address.
REQ-009 The block SHALL have port upd_valid_i  input  1  resolved branch or jump training strobe.
REQ-010 The block SHALL have port upd_pc_i  input  XLEN  PC of the resolved control-flow instruction.
REQ-011 The block SHALL have port upd_taken_i  input  1  resolved direction.
REQ-012 The block SHALL have port upd_target_i  input  XLEN  resolved target address.
REQ-013 The block SHALL have port pc_o  output  XLEN  registered fetch PC.
REQ-014 The block SHALL have port pred_taken_o  output  1  prediction for pc_o is taken.
REQ-015 The block SHALL have port pred_target_o  output  XLEN  predicted target for pc_o; 0 when pred_taken_o=0.

Function
REQ-016 The index SHALL be pc[IDX+1:2] with IDX=log2(BTB_ENTRIES); the tag SHALL be pc[XLEN-1:IDX+2].
REQ-017 Each entry SHALL hold valid, tag, target (XLEN), and a 2-bit saturating counter, encoded 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 A lookup SHALL be combinational on pc_o; hit = valid and tag match; pred_taken_o = hit and counter[1].
REQ-019 The next PC SHALL follow this priority: redirect_i gives redirect_pc_i; otherwise stall_i gives pc_o; otherwise pred_taken_o gives the entry target; otherwise pc_o+4, wrapping modulo 2^XLEN.
REQ-020 Bits [1:0] of every loaded PC SHALL be forced to 00.
REQ-021 redirect_i SHALL override stall_i in the same cycle.
REQ-022 A training hit (upd_valid_i, valid, tag match) SHALL increment the counter on taken and decrement it on not taken, saturating at 11 and 00; on taken the target SHALL be replaced by upd_target_i.
REQ-023 A training miss with upd_taken_i=1 SHALL allocate or overwrite the indexed entry: valid=1, new tag, target=upd_target_i, counter=10.
REQ-024 A training miss with upd_taken_i=0 SHALL leave the BTB unchanged.
REQ-025 When training and lookup hit the same index in one cycle, the lookup SHALL see the pre-update contents; the update SHALL be visible from the next cycle.
REQ-026 Training SHALL proceed regardless of stall_i and redirect_i.
REQ-027 Latency: pc_o SHALL change exactly one clock edge after the inputs that select it.

Reset
REQ-028 On rst low, asynchronously: pc_o=RESET_PC, all valid bits=0, all counters=01, pred_taken_o=0, pred_target_o=0.
REQ-029 Reset asserted mid-operation SHALL discard any pending update and redirect; the first edge after release SHALL fetch from RESET_PC+4, or from redirect_pc_i if redirect_i is asserted.

Structure
REQ-030 Package fetch_pkg SHALL hold the counter encoding constants (SNT, WNT, WT, ST) and the btb_entry_t struct, parameterised by width through localparams derived at use.
REQ-031 BTB storage plus saturating-counter update logic SHALL live in sub-module btb; fetch_pc_unit SHALL contain the PC register and next-PC mux.

Verification
REQ-032 Reset check: release rst with no stimulus -> pc_o = 0x0, 0x4, 0x8 on successive edges, pred_taken_o=0.
REQ-033 Allocation: train pc=0x10 taken target=0x40, then fetch reaches 0x10 -> pred_taken_o=1, pred_target_o=0x40, next pc_o=0x40.
REQ-034 Saturation: train pc=0x10 taken four times, then not-taken once -> counter 11→10, still predicts taken; a second not-taken gives 01 and no prediction, so pc_o=0x14 follows 0x10.
REQ-035 Priority: stall_i=1 and redirect_i=1 with redirect_pc_i=0x203 at pc_o=0x8 -> pc_o=0x200 next edge; stall_i alone -> pc_o holds.
REQ-036 Aliasing (BTB_ENTRIES=16): train 0x10 taken to 0x40, then 0x50 taken to 0x80 (same index) -> fetch at 0x10 gives no hit, fetch at 0x50 gives target 0x80.
REQ-037 Same-cycle read/write and wrap: update at the lookup index is ignored by that cycle's prediction; pc_o=0xFFFFFFFC with no hit -> next pc_o=0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC unit and its branch target buffer.
//   - 2-bit saturating counter encodings (SNT, WNT, WT, ST)
//   - btb_entry_t: one BTB entry. Tag and target are sized to BTB_MAX_W.
//     Users zero-extend on write and truncate on read to their own XLEN,
//     so the unused upper bits are constant and trim away in synthesis.
//   - ctr_next: saturating counter update
package fetch_pkg;

    localparam int BTB_MAX_W = 64;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
        logic [1:0]           ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
        else       return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_btb.sv
// Branch target buffer: direct-mapped, with a 2-bit saturating counter per entry.
// Ports:
//   clk, rst                 clock, async active-low reset
//   lookup_pc                fetch PC looked up combinationally
//   pred_taken, pred_target  prediction for lookup_pc (target 0 when not taken)
//   upd_valid, upd_pc,
//   upd_taken, upd_target    training from resolved control flow
// Training writes on the clock edge, so a lookup in the same cycle sees the
// old contents.
module btb
    import fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX = $clog2(ENTRIES);

    btb_entry_t mem [ENTRIES];

    // PCs are word aligned; the low two bits never take part in index or tag.
    logic unused_lo;
    assign unused_lo = ^{lookup_pc[1:0], upd_pc[1:0]};

    logic [IDX-1:0] rd_idx, wr_idx;
    btb_entry_t     rd, wr;
    logic           rd_hit, wr_hit;

    assign rd_idx = lookup_pc[IDX+1:2];
    assign wr_idx = upd_pc[IDX+1:2];
    assign rd     = mem[rd_idx];
    assign wr     = mem[wr_idx];
    assign rd_hit = rd.valid && (rd.tag == BTB_MAX_W'(lookup_pc[XLEN-1:IDX+2]));
    assign wr_hit = wr.valid && (wr.tag == BTB_MAX_W'(upd_pc[XLEN-1:IDX+2]));

    assign pred_taken  = rd_hit && rd.ctr[1];
    assign pred_target = pred_taken ? XLEN'(rd.target) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++)
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
        end else if (upd_valid) begin
            if (wr_hit) begin
                mem[wr_idx].ctr <= ctr_next(wr.ctr, upd_taken);
                if (upd_taken)
                    mem[wr_idx].target <= BTB_MAX_W'(upd_target);
            end else if (upd_taken) begin
                // Miss on a taken branch: allocate (or evict an alias) weakly taken.
                mem[wr_idx] <= '{valid:  1'b1,
                                 tag:    BTB_MAX_W'(upd_pc[XLEN-1:IDX+2]),
                                 target: BTB_MAX_W'(upd_target),
                                 ctr:    WT};
            end
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with BTB-driven next-PC selection.
// Ports:
//   clk, rst                       clock, async active-low reset
//   stall_i                        hold current PC
//   redirect_i, redirect_pc_i      correction from execute (beats stall)
//   upd_valid_i, upd_pc_i,
//   upd_taken_i, upd_target_i      BTB training, independent of stall/redirect
//   pc_o                           registered fetch PC
//   pred_taken_o, pred_target_o    BTB prediction for pc_o
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] nxt;

    btb #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_o),
        .pred_taken  (pred_taken_o),
        .pred_target (pred_target_o),
        .upd_valid   (upd_valid_i),
        .upd_pc      (upd_pc_i),
        .upd_taken   (upd_taken_i),
        .upd_target  (upd_target_i)
    );

    always_comb begin
        if (redirect_i)        nxt = redirect_pc_i;
        else if (stall_i)      nxt = pc_o;
        else if (pred_taken_o) nxt = pred_target_o;
        else                   nxt = pc_o + XLEN'(4);   // wraps mod 2^XLEN
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_o <= RESET_PC & ALIGN_MASK;
        else      pc_o <= nxt & ALIGN_MASK;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;

    int passed = 0;
    int total  = 0;

    fetch_pc_unit #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .pc_o          (pc_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling / driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        step();
        upd_valid_i  = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        step();
        redirect_i    = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); else passed++;
        total++; if (pred_taken_o !== 1'b0) $display("FAIL reset_pred: got %b want 0", pred_taken_o); else passed++;
        total++; if (pred_target_o !== 32'h0) $display("FAIL reset_tgt: got %h want 0", pred_target_o); else passed++;
        @(negedge clk);
        rst = 1'b1;
        step();
        total++; if (pc_o !== 32'h4) $display("FAIL reset_seq1: got %h want %h", pc_o, 32'h4); else passed++;
        step();
        total++; if (pc_o !== 32'h8) $display("FAIL reset_seq2: got %h want %h", pc_o, 32'h8); else passed++;
        total++; if (pred_taken_o !== 1'b0) $display("FAIL reset_seq_pred: got %b want 0", pred_taken_o); else passed++;
    endtask

    task automatic test_priority();
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
        step();
        total++; if (pc_o !== 32'h200) $display("FAIL prio_redirect: got %h want %h", pc_o, 32'h200); else passed++;
        redirect_i = 1'b0;
        step();
        total++; if (pc_o !== 32'h200) $display("FAIL prio_stall: got %h want %h", pc_o, 32'h200); else passed++;
        stall_i = 1'b0;
        step();
        total++; if (pc_o !== 32'h204) $display("FAIL prio_resume: got %h want %h", pc_o, 32'h204); else passed++;
    endtask

    task automatic test_alloc();
        train(32'h10, 1'b1, 32'h40);
        redirect_to(32'h10);
        total++; if (pred_taken_o !== 1'b1) $display("FAIL alloc_pred: got %b want 1", pred_taken_o); else passed++;
        total++; if (pred_target_o !== 32'h40) $display("FAIL alloc_tgt: got %h want %h", pred_target_o, 32'h40); else passed++;
        step();
        total++; if (pc_o !== 32'h40) $display("FAIL alloc_follow: got %h want %h", pc_o, 32'h40); else passed++;
        total++; if (pred_taken_o !== 1'b0) $display("FAIL alloc_nohit: got %b want 0", pred_taken_o); else passed++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) train(32'h10, 1'b1, 32'h40);
        train(32'h10, 1'b0, 32'h0);         // 11 -> 10
        redirect_to(32'h10);
        total++; if (pred_taken_o !== 1'b1) $display("FAIL sat_wt_pred: got %b want 1", pred_taken_o); else passed++;
        train(32'h10, 1'b0, 32'h0);         // 10 -> 01
        redirect_to(32'h10);
        total++; if (pred_taken_o !== 1'b0) $display("FAIL sat_wnt_pred: got %b want 0", pred_taken_o); else passed++;
        total++; if (pred_target_o !== 32'h0) $display("FAIL sat_wnt_tgt: got %h want 0", pred_target_o); else passed++;
        step();
        total++; if (pc_o !== 32'h14) $display("FAIL sat_seq: got %h want %h", pc_o, 32'h14); else passed++;
    endtask

    task automatic test_alias();
        train(32'h10, 1'b1, 32'h40);        // hit: 01 -> 10
        train(32'h50, 1'b1, 32'h80);        // same index, new tag: evicts
        redirect_to(32'h10);
        total++; if (pred_taken_o !== 1'b0) $display("FAIL alias_old: got %b want 0", pred_taken_o); else passed++;
        redirect_to(32'h50);
        total++; if (pred_taken_o !== 1'b1) $display("FAIL alias_new_pred: got %b want 1", pred_taken_o); else passed++;
        total++; if (pred_target_o !== 32'h80) $display("FAIL alias_new_tgt: got %h want %h", pred_target_o, 32'h80); else passed++;
        step();
        total++; if (pc_o !== 32'h80) $display("FAIL alias_follow: got %h want %h", pc_o, 32'h80); else passed++;
    endtask

    task automatic test_same_cycle();
        redirect_to(32'h50);
        upd_valid_i = 1'b1; upd_pc_i = 32'h50; upd_taken_i = 1'b1; upd_target_i = 32'h90;
        #1;
        total++; if (pred_target_o !== 32'h80) $display("FAIL rw_same_tgt: got %h want %h", pred_target_o, 32'h80); else passed++;
        step();
        upd_valid_i = 1'b0;
        total++; if (pc_o !== 32'h80) $display("FAIL rw_old_follow: got %h want %h", pc_o, 32'h80); else passed++;
        redirect_to(32'h50);
        total++; if (pred_target_o !== 32'h90) $display("FAIL rw_new_tgt: got %h want %h", pred_target_o, 32'h90); else passed++;
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        total++; if (pred_taken_o !== 1'b0) $display("FAIL wrap_nohit: got %b want 0", pred_taken_o); else passed++;
        step();
        total++; if (pc_o !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc_o); else passed++;
    endtask

    task automatic test_midreset();
        redirect_to(32'h100);
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        upd_valid_i = 1'b1; upd_pc_i = 32'h20; upd_taken_i = 1'b1; upd_target_i = 32'h60;
        #2 rst = 1'b0;
        #1;
        total++; if (pc_o !== 32'h0) $display("FAIL mid_rst_pc: got %h want 0", pc_o); else passed++;
        total++; if (pred_taken_o !== 1'b0) $display("FAIL mid_rst_pred: got %b want 0", pred_taken_o); else passed++;
        redirect_i = 1'b0; upd_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        total++; if (pc_o !== 32'h4) $display("FAIL mid_rel_pc: got %h want %h", pc_o, 32'h4); else passed++;
        redirect_to(32'h50);
        total++; if (pred_taken_o !== 1'b0) $display("FAIL mid_btb_clear: got %b want 0", pred_taken_o); else passed++;
        redirect_to(32'h20);
        total++; if (pred_taken_o !== 1'b0) $display("FAIL mid_upd_drop: got %b want 0", pred_taken_o); else passed++;
        // Reset released while a redirect is already waiting.
        #2 rst = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h120;
        @(negedge clk);
        rst = 1'b1;
        step();
        redirect_i = 1'b0;
        total++; if (pc_o !== 32'h120) $display("FAIL mid_rel_redirect: got %h want %h", pc_o, 32'h120); else passed++;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_alloc();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_wrap();
        test_midreset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
